// File: rtl/vga_pkg.sv
// Shared VGA constants and types for the pixel-content generators.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

    localparam int H_RES = 640;
    localparam int V_RES = 480;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic {FWD, REV} dir_t;

    localparam rgb_t COLOR_BLACK = 24'h000000;
    localparam rgb_t COLOR_WHITE = 24'hFFFFFF;

endpackage

// File: rtl/vga_axis_bouncer.sv
// One axis of the bouncing box: position register plus FWD/REV direction FSM.
// Latency: Pos updates on the edge after Tick is seen high.
// Backpressure: none; Tick is a one-cycle strobe.
module vga_axis_bouncer
    import vga_pkg::*;
#(
    parameter int LIM  = 576,
    parameter int STEP = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Tick,
    output logic [9:0] Pos
);

    localparam logic [10:0] LIM_W  = 11'(LIM);
    localparam logic [10:0] STEP_W = 11'(STEP);

    dir_t        dir;
    logic [10:0] pos_w;

    assign pos_w = {1'b0, Pos};

    // Landing exactly on a bound flips direction in the same update.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Pos <= '0;
            dir <= FWD;
        end else if (Tick) begin
            case (dir)
                FWD: begin
                    if (pos_w + STEP_W >= LIM_W) begin
                        Pos <= LIM_W[9:0];
                        dir <= REV;
                    end else begin
                        Pos <= Pos + STEP_W[9:0];
                    end
                end
                REV: begin
                    if (pos_w <= STEP_W) begin
                        Pos <= '0;
                        dir <= FWD;
                    end else begin
                        Pos <= Pos - STEP_W[9:0];
                    end
                end
                default: dir <= FWD;
            endcase
        end
    end

endmodule

// File: rtl/vga_bouncing_box.sv
// Bouncing-box pixel source (VGA_BOX_BORDER_EN adds a white box outline).
// Latency: RGB one clock after (Linha, Coluna); FrameTick one clock after frame end.
// Backpressure: none; follows the coordinates every clock.
module vga_bouncing_box
    import vga_pkg::*;
#(
    parameter int   BOX_W     = 64,
    parameter int   BOX_H     = 48,
    parameter int   STEP      = 2,
    parameter rgb_t BOX_COLOR = 24'hFF0000,
    parameter rgb_t BG_COLOR  = 24'h0000FF
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [9:0] Linha,
    input  logic [9:0] Coluna,
    output rgb_t       RGB,
    output logic       FrameTick,
    output logic [9:0] BoxX,
    output logic [9:0] BoxY
);

    localparam logic [10:0] H_RES_W = 11'(H_RES);
    localparam logic [10:0] V_RES_W = 11'(V_RES);
    localparam logic [10:0] BOX_W_W = 11'(BOX_W);
    localparam logic [10:0] BOX_H_W = 11'(BOX_H);
    localparam logic [9:0]  LAST_L  = 10'(V_RES - 1);
    localparam logic [9:0]  LAST_C  = 10'(H_RES - 1);

    logic [9:0]  prev_linha;
    logic [9:0]  prev_coluna;
    logic        frame_end;
    logic [10:0] lin_w, col_w, bx_w, by_w;
    logic        in_box;
    rgb_t        pix_color;

    assign lin_w = {1'b0, Linha};
    assign col_w = {1'b0, Coluna};
    assign bx_w  = {1'b0, BoxX};
    assign by_w  = {1'b0, BoxY};

    // Blanking holds the last coordinate, so only the transition into it counts.
    assign frame_end = (Linha == LAST_L) && (Coluna == LAST_C) &&
                       ({Linha, Coluna} != {prev_linha, prev_coluna});

    assign in_box = (col_w >= bx_w) && (col_w < bx_w + BOX_W_W) &&
                    (lin_w >= by_w) && (lin_w < by_w + BOX_H_W);

    always_comb begin
        pix_color = BG_COLOR;
        if (col_w >= H_RES_W || lin_w >= V_RES_W) begin
            pix_color = COLOR_BLACK;
        end else if (in_box) begin
`ifdef VGA_BOX_BORDER_EN
            if (col_w == bx_w || col_w == bx_w + BOX_W_W - 11'd1 ||
                lin_w == by_w || lin_w == by_w + BOX_H_W - 11'd1) begin
                pix_color = COLOR_WHITE;
            end else begin
                pix_color = BOX_COLOR;
            end
`else
            pix_color = BOX_COLOR;
`endif
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            RGB         <= COLOR_BLACK;
            FrameTick   <= 1'b0;
            prev_linha  <= '0;
            prev_coluna <= '0;
        end else begin
            RGB         <= pix_color;
            FrameTick   <= frame_end;
            prev_linha  <= Linha;
            prev_coluna <= Coluna;
        end
    end

    vga_axis_bouncer #(.LIM(H_RES - BOX_W), .STEP(STEP)) u_x (
        .Clock (Clock),
        .Reset (Reset),
        .Tick  (FrameTick),
        .Pos   (BoxX)
    );

    vga_axis_bouncer #(.LIM(V_RES - BOX_H), .STEP(STEP)) u_y (
        .Clock (Clock),
        .Reset (Reset),
        .Tick  (FrameTick),
        .Pos   (BoxY)
    );

endmodule

// File: tb/tb_vga_bouncing_box.sv
// Scoreboard bench for vga_bouncing_box: each driven cycle queues its expected
// outputs; a monitor pops and compares one item per clock after the edge.
module tb_vga_bouncing_box;

    logic        Clock;
    logic        Reset;
    logic [9:0]  Linha;
    logic [9:0]  Coluna;
    logic [23:0] RGB;
    logic        FrameTick;
    logic [9:0]  BoxX;
    logic [9:0]  BoxY;

    vga_bouncing_box dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Linha     (Linha),
        .Coluna    (Coluna),
        .RGB       (RGB),
        .FrameTick (FrameTick),
        .BoxX      (BoxX),
        .BoxY      (BoxY)
    );

    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] BLUE  = 24'h0000FF;
    localparam logic [23:0] BLACK = 24'h000000;
`ifdef VGA_BOX_BORDER_EN
    localparam logic [23:0] EDGE_COL = 24'hFFFFFF;
`else
    localparam logic [23:0] EDGE_COL = 24'hFF0000;
`endif

    typedef struct {
        int          id;
        bit          c_rgb;
        logic [23:0] rgb;
        bit          c_tick;
        logic        tick;
        bit          c_box;
        logic [9:0]  bx;
        logic [9:0]  by;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   vec_id = 0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic drive(input logic rst, input logic [9:0] l, input logic [9:0] c,
                         input bit crgb, input logic [23:0] ergb,
                         input bit ctick, input logic etick,
                         input bit cbox, input logic [9:0] ebx, input logic [9:0] eby);
        exp_t e;
        @(negedge Clock);
        Reset  = rst;
        Linha  = l;
        Coluna = c;
        e.id = vec_id; e.c_rgb = crgb; e.rgb = ergb; e.c_tick = ctick; e.tick = etick;
        e.c_box = cbox; e.bx = ebx; e.by = eby;
        sb.push_back(e);
        vec_id++;
    endtask

    always @(posedge Clock) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.c_rgb) begin
                tests++;
                if (RGB !== e.rgb) begin
                    fails++;
                    $display("FAIL rgb vec%0d: got %h want %h", e.id, RGB, e.rgb);
                end
            end
            if (e.c_tick) begin
                tests++;
                if (FrameTick !== e.tick) begin
                    fails++;
                    $display("FAIL tick vec%0d: got %b want %b", e.id, FrameTick, e.tick);
                end
            end
            if (e.c_box) begin
                tests++;
                if (BoxX !== e.bx || BoxY !== e.by) begin
                    fails++;
                    $display("FAIL box vec%0d: got (%0d,%0d) want (%0d,%0d)",
                             e.id, BoxX, BoxY, e.bx, e.by);
                end
            end
        end
    end

    // Hand-computed box positions after n completed frames.
    task automatic ckpt(input int n, output bit chk, output logic [9:0] x, output logic [9:0] y);
        chk = 1'b1;
        case (n)
            2:       begin x = 10'd4;   y = 10'd4;   end
            216:     begin x = 10'd432; y = 10'd432; end
            217:     begin x = 10'd434; y = 10'd430; end
            288:     begin x = 10'd576; y = 10'd288; end
            289:     begin x = 10'd574; y = 10'd286; end
            576:     begin x = 10'd0;   y = 10'd288; end
            577:     begin x = 10'd2;   y = 10'd290; end
            default: begin chk = 1'b0; x = '0; y = '0; end
        endcase
    endtask

    initial begin
        bit         chk;
        logic [9:0] ex, ey;
        int         guard;
        Reset  = 1'b1;
        Linha  = 10'd5;
        Coluna = 10'd5;

        // Reset held three cycles, then release inside the box.
        repeat (3) drive(1, 10'd5, 10'd5, 1, BLACK, 1, 1'b0, 1, 10'd0, 10'd0);
        drive(0, 10'd5, 10'd5, 1, RED, 1, 1'b0, 1, 10'd0, 10'd0);

        // Colour rule and one-cycle latency.
        drive(0, 10'd10,  10'd63,  1, EDGE_COL, 1, 1'b0, 0, '0, '0);
        drive(0, 10'd10,  10'd64,  1, BLUE,     1, 1'b0, 0, '0, '0);
        drive(0, 10'd200, 10'd700, 1, BLACK,    1, 1'b0, 0, '0, '0);
        drive(0, 10'd480, 10'd5,   1, BLACK,    0, 1'b0, 0, '0, '0);
        drive(0, 10'd40,  10'd10,  1, RED,      0, 1'b0, 0, '0, '0);
        drive(0, 10'd48,  10'd10,  1, BLUE,     0, 1'b0, 0, '0, '0);
`ifdef VGA_BOX_BORDER_EN
        drive(0, 10'd0,  10'd30, 1, 24'hFFFFFF, 0, 1'b0, 0, '0, '0);
        drive(0, 10'd10, 10'd30, 1, 24'hFF0000, 0, 1'b0, 0, '0, '0);
        drive(0, 10'd47, 10'd63, 1, 24'hFFFFFF, 0, 1'b0, 0, '0, '0);
`endif

        // Last visible line, then blanking hold: exactly one tick.
        for (int c = 0; c < 639; c++)
            drive(0, 10'd479, 10'(c), 0, '0, 1, 1'b0, 0, '0, '0);
        drive(0, 10'd479, 10'd639, 1, BLUE, 1, 1'b1, 1, 10'd0, 10'd0);
        drive(0, 10'd479, 10'd639, 0, '0, 1, 1'b0, 1, 10'd2, 10'd2);
        for (int i = 1; i < 160; i++)
            drive(0, 10'd479, 10'd639, 0, '0, 1, 1'b0, 0, '0, '0);

        // Compressed frames: one pass through the frame-end coordinate each.
        for (int f = 2; f <= 577; f++) begin
            ckpt(f - 1, chk, ex, ey);
            drive(0, 10'd0, 10'd0, 0, '0, 1, 1'b0, chk, ex, ey);
            drive(0, 10'd479, 10'd639, 0, '0, 1, 1'b1, 0, '0, '0);
        end
        ckpt(577, chk, ex, ey);
        drive(0, 10'd0, 10'd0, 0, '0, 1, 1'b0, chk, ex, ey);

        // Reset mid-frame, then the first tick comes back at the frame end.
        drive(1, 10'd100, 10'd100, 1, BLACK, 1, 1'b0, 1, 10'd0, 10'd0);
        drive(0, 10'd479, 10'd639, 1, BLUE, 1, 1'b1, 1, 10'd0, 10'd0);
        drive(0, 10'd479, 10'd639, 0, '0, 1, 1'b0, 1, 10'd2, 10'd2);

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge Clock);
            guard++;
        end
        #2;
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d items left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
